// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline-boundary definitions for the RISC-V core.
// Provides the default datapath widths and the MEM/WB payload layout.
package riscv_pipe_pkg;

   localparam int unsigned XLEN_DEFAULT = 64;
   localparam int unsigned REGW_DEFAULT = 5;

   typedef struct packed {
      logic                      reg_write;
      logic                      mem_to_reg;
      logic [XLEN_DEFAULT-1:0]   read_data;
      logic [XLEN_DEFAULT-1:0]   alu_result;
      logic [REGW_DEFAULT-1:0]   rd;
   } mem_wb_payload_t;

   localparam int unsigned MEM_WB_PAYLOAD_W = $bits(mem_wb_payload_t);

endpackage

// File: rtl/pipe_skid_buffer.sv
// Generic 2-entry valid/ready skid buffer used at every pipeline boundary.
// Outputs come straight from the head flops; in_ready depends on state only.
module pipe_skid_buffer #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic [W-1:0] head_q;
   logic [W-1:0] head_d;
   logic [W-1:0] skid_q;
   logic [W-1:0] skid_d;
   logic         head_valid_q;
   logic         head_valid_d;
   logic         skid_valid_q;
   logic         skid_valid_d;
   logic         accept_s;
   logic         pop_s;

   assign in_ready  = !skid_valid_q;
   assign out_valid = head_valid_q;
   assign out_data  = head_q;
   assign accept_s  = in_valid & !skid_valid_q;
   assign pop_s     = head_valid_q & out_ready;

   // Next-state selection; flush squashes the update even if an input is accepted.
   always_comb begin
      head_d       = head_q;
      skid_d       = skid_q;
      head_valid_d = head_valid_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
         head_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!head_valid_q || (pop_s && !skid_valid_q)) begin
         if (accept_s) begin
            head_d       = in_data;
            head_valid_d = 1'b1;
         end else begin
            head_valid_d = 1'b0;
         end
      end else if (pop_s && skid_valid_q) begin
         head_d       = skid_q;
         skid_valid_d = 1'b0;
      end else if (accept_s) begin
         skid_d       = in_data;
         skid_valid_d = 1'b1;
      end else begin
         head_valid_d = head_valid_q;
      end
   end

   // State registers; reset clears payloads as well so outputs read 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q       <= {W{1'b0}};
         skid_q       <= {W{1'b0}};
         head_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
      end else begin
         head_q       <= head_d;
         skid_q       <= skid_d;
         head_valid_q <= head_valid_d;
         skid_valid_q <= skid_valid_d;
      end
   end

endmodule

// File: rtl/mem_wb_skid_stage.sv
// MEM/WB boundary: handshaked skid buffer plus final write-back data/enable,
// so the WB stage is only wiring into the register file.
module mem_wb_skid_stage
   import riscv_pipe_pkg::*;
#(
   parameter int unsigned XLEN              = XLEN_DEFAULT,
   parameter int unsigned REGW              = REGW_DEFAULT,
   parameter bit          ZERO_REG_SUPPRESS = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            flush,
   input  logic            RegWrite,
   input  logic            MemtoReg,
   input  logic [XLEN-1:0] ReadData,
   input  logic [XLEN-1:0] ALU_result,
   input  logic [REGW-1:0] rd,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            RegWrite_store,
   output logic            MemtoReg_store,
   output logic [XLEN-1:0] ReadData_store,
   output logic [XLEN-1:0] ALU_result_store,
   output logic [REGW-1:0] rd_store,
   output logic [XLEN-1:0] wb_data,
   output logic            wb_en
);

   // Same field order as mem_wb_payload_t, widened to this instance's parameters.
   typedef struct packed {
      logic              reg_write;
      logic              mem_to_reg;
      logic [XLEN-1:0]   read_data;
      logic [XLEN-1:0]   alu_result;
      logic [REGW-1:0]   rd;
   } payload_t;

   localparam int unsigned PW = $bits(payload_t);

   payload_t in_payload_s;
   payload_t head_payload_s;
   logic     zero_dest_s;

   assign in_payload_s.reg_write  = RegWrite;
   assign in_payload_s.mem_to_reg = MemtoReg;
   assign in_payload_s.read_data  = ReadData;
   assign in_payload_s.alu_result = ALU_result;
   assign in_payload_s.rd         = rd;

   pipe_skid_buffer #(
      .W (PW)
   ) u_skid (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_payload_s),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (head_payload_s)
   );

   assign RegWrite_store   = out_valid & head_payload_s.reg_write;
   assign MemtoReg_store   = head_payload_s.mem_to_reg;
   assign ReadData_store   = head_payload_s.read_data;
   assign ALU_result_store = head_payload_s.alu_result;
   assign rd_store         = head_payload_s.rd;

   assign wb_data     = MemtoReg_store ? ReadData_store : ALU_result_store;
   assign zero_dest_s = ZERO_REG_SUPPRESS && (rd_store == {REGW{1'b0}});
   // Commit happens on the handshake itself, so it may fire in a flush cycle.
   assign wb_en       = out_valid & out_ready & RegWrite_store & !zero_dest_s;

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Randomized and directed bench for mem_wb_skid_stage against a queue model.
module tb_mem_wb_skid_stage;
   import riscv_pipe_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        flush = 1'b0;
   logic        RegWrite = 1'b0;
   logic        MemtoReg = 1'b0;
   logic [63:0] ReadData = 64'd0;
   logic [63:0] ALU_result = 64'd0;
   logic [4:0]  rd = 5'd0;
   logic        out_ready = 1'b0;

   logic        in_ready, out_valid, RegWrite_store, MemtoReg_store, wb_en;
   logic [63:0] ReadData_store, ALU_result_store, wb_data;
   logic [4:0]  rd_store;
   logic        in_ready0, out_valid0, RegWrite_store0, MemtoReg_store0, wb_en0;
   logic [63:0] ReadData_store0, ALU_result_store0, wb_data0;
   logic [4:0]  rd_store0;

   int errors = 0;
   int checks = 0;
   mem_wb_payload_t mq[$];

   always #5 clk = ~clk;

   mem_wb_skid_stage #(.XLEN(64), .REGW(5), .ZERO_REG_SUPPRESS(1'b1)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
      .RegWrite(RegWrite), .MemtoReg(MemtoReg), .ReadData(ReadData), .ALU_result(ALU_result),
      .rd(rd), .out_valid(out_valid), .out_ready(out_ready), .RegWrite_store(RegWrite_store),
      .MemtoReg_store(MemtoReg_store), .ReadData_store(ReadData_store),
      .ALU_result_store(ALU_result_store), .rd_store(rd_store), .wb_data(wb_data), .wb_en(wb_en));

   mem_wb_skid_stage #(.XLEN(64), .REGW(5), .ZERO_REG_SUPPRESS(1'b0)) dut0 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0), .flush(flush),
      .RegWrite(RegWrite), .MemtoReg(MemtoReg), .ReadData(ReadData), .ALU_result(ALU_result),
      .rd(rd), .out_valid(out_valid0), .out_ready(out_ready), .RegWrite_store(RegWrite_store0),
      .MemtoReg_store(MemtoReg_store0), .ReadData_store(ReadData_store0),
      .ALU_result_store(ALU_result_store0), .rd_store(rd_store0), .wb_data(wb_data0), .wb_en(wb_en0));

   function automatic mem_wb_payload_t cur_in();
      mem_wb_payload_t p;
      p.reg_write  = RegWrite;
      p.mem_to_reg = MemtoReg;
      p.read_data  = ReadData;
      p.alu_result = ALU_result;
      p.rd         = rd;
      return p;
   endfunction

   // Advance one clock and apply the FIFO-of-two rules to the model.
   task automatic tick();
      bit acc, pop, fl;
      mem_wb_payload_t p;
      acc = in_valid && (mq.size() < 2);
      pop = (mq.size() > 0) && out_ready;
      fl  = flush;
      p   = cur_in();
      @(posedge clk);
      if (fl) mq.delete();
      else begin
         if (pop) void'(mq.pop_front());
         if (acc) mq.push_back(p);
      end
      @(negedge clk);
   endtask

   task automatic drive(input bit v, input bit rw, input bit mr, input logic [63:0] rdat,
                        input logic [63:0] alu, input logic [4:0] r);
      in_valid = v; RegWrite = rw; MemtoReg = mr; ReadData = rdat; ALU_result = alu; rd = r;
   endtask

   task automatic test_reset();
      // Initial reset state
      #1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || wb_en !== 1'b0) begin
         errors++; $display("FAIL reset_init: ov=%b ir=%b en=%b want 0 1 0", out_valid, in_ready, wb_en);
      end
      @(negedge clk); reset = 1'b0;
      out_ready = 1'b0;
      drive(1, 1, 0, 64'h11, 64'h22, 5'd3); tick();
      drive(1, 1, 1, 64'h33, 64'h44, 5'd4); tick();
      in_valid = 1'b0; out_ready = 1'b1;
      reset = 1'b1; mq.delete();
      #1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || wb_en !== 1'b0 || RegWrite_store !== 1'b0) begin
         errors++; $display("FAIL reset_mid: ov=%b ir=%b en=%b rw=%b want 0 1 0 0", out_valid, in_ready, wb_en, RegWrite_store);
      end
      checks++; if (MemtoReg_store !== 1'b0 || ReadData_store !== 64'd0 || ALU_result_store !== 64'd0 ||
                    rd_store !== 5'd0 || wb_data !== 64'd0) begin
         errors++; $display("FAIL reset_payload: mr=%b rdat=%h alu=%h rd=%h wbd=%h want all 0",
                            MemtoReg_store, ReadData_store, ALU_result_store, rd_store, wb_data);
      end
      @(negedge clk); reset = 1'b0;
      out_ready = 1'b0;
      drive(1, 1, 0, 64'h0, 64'h5A5A, 5'd9); #1;
      checks++; if (out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_latency_early: out_valid=%b want 0", out_valid);
      end
      tick(); in_valid = 1'b0; #1;
      checks++; if (out_valid !== 1'b1 || rd_store !== 5'd9 || ALU_result_store !== 64'h5A5A) begin
         errors++; $display("FAIL reset_first: ov=%b rd=%0d alu=%h want 1 9 5a5a", out_valid, rd_store, ALU_result_store);
      end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
   endtask

   task automatic test_stream();
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         drive(1, 1, 0, 64'hFFFF, 64'(i) * 64'h10, 5'(i)); #1;
         checks++; if (in_ready !== 1'b1) begin
            errors++; $display("FAIL stream_ready[%0d]: in_ready=%b want 1", i, in_ready);
         end
         tick();
         in_valid = 1'b0; #1;
         checks++; if (wb_en !== 1'b1 || wb_data !== 64'(i) * 64'h10) begin
            errors++; $display("FAIL stream_wb[%0d]: en=%b data=%h want 1 %h", i, wb_en, wb_data, 64'(i) * 64'h10);
         end
         if (i < 8) drive(1, 1, 0, 64'hFFFF, 64'(i + 1) * 64'h10, 5'(i + 1));
         if (i < 8) i = i; // keep structure simple; next iteration re-drives the same item
      end
      in_valid = 1'b0; tick();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      drive(1, 1, 0, 64'd0, 64'hA, 5'd3); tick();
      drive(1, 1, 0, 64'd0, 64'hB, 5'd4); tick();
      drive(1, 1, 0, 64'd0, 64'hC, 5'd5); #1;
      checks++; if (in_ready !== 1'b0 || rd_store !== 5'd3 || out_valid !== 1'b1) begin
         errors++; $display("FAIL bp_full: ir=%b rd=%0d ov=%b want 0 3 1", in_ready, rd_store, out_valid);
      end
      tick(); #1;
      checks++; if (in_ready !== 1'b0 || rd_store !== 5'd3) begin
         errors++; $display("FAIL bp_c_rejected: ir=%b rd=%0d want 0 3", in_ready, rd_store);
      end
      out_ready = 1'b1; #1;
      checks++; if (wb_en !== 1'b1 || wb_data !== 64'hA) begin
         errors++; $display("FAIL bp_retire_a: en=%b data=%h want 1 a", wb_en, wb_data);
      end
      tick(); #1;
      checks++; if (rd_store !== 5'd4 || wb_en !== 1'b1 || in_ready !== 1'b1) begin
         errors++; $display("FAIL bp_retire_b: rd=%0d en=%b ir=%b want 4 1 1", rd_store, wb_en, in_ready);
      end
      tick(); in_valid = 1'b0; #1;
      checks++; if (rd_store !== 5'd5 || wb_en !== 1'b1 || wb_data !== 64'hC) begin
         errors++; $display("FAIL bp_retire_c: rd=%0d en=%b data=%h want 5 1 c", rd_store, wb_en, wb_data);
      end
      tick(); #1;
      checks++; if (out_valid !== 1'b0) begin
         errors++; $display("FAIL bp_drained: out_valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_load_and_x0();
      out_ready = 1'b1;
      drive(1, 1, 1, 64'hDEADBEEF_00000001, 64'h1000, 5'd7); tick(); in_valid = 1'b0; #1;
      checks++; if (wb_data !== 64'hDEADBEEF_00000001 || wb_en !== 1'b1) begin
         errors++; $display("FAIL load: data=%h en=%b want deadbeef00000001 1", wb_data, wb_en);
      end
      drive(1, 1, 0, 64'd0, 64'h77, 5'd0); tick(); in_valid = 1'b0; #1;
      checks++; if (out_valid !== 1'b1 || wb_en !== 1'b0) begin
         errors++; $display("FAIL x0_suppress: ov=%b en=%b want 1 0", out_valid, wb_en);
      end
      checks++; if (out_valid0 !== 1'b1 || wb_en0 !== 1'b1) begin
         errors++; $display("FAIL x0_nosuppress: ov=%b en=%b want 1 1", out_valid0, wb_en0);
      end
      tick();
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      drive(1, 1, 0, 64'd0, 64'h1, 5'd1); tick();
      drive(1, 1, 0, 64'd0, 64'h2, 5'd2); tick();
      drive(1, 1, 0, 64'd0, 64'h99, 5'd9); flush = 1'b1; tick();
      flush = 1'b0; in_valid = 1'b0; #1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || RegWrite_store !== 1'b0) begin
         errors++; $display("FAIL flush_clear: ov=%b ir=%b rw=%b want 0 1 0", out_valid, in_ready, RegWrite_store);
      end
      out_ready = 1'b1; tick(); #1;
      checks++; if (out_valid !== 1'b0 || wb_en !== 1'b0) begin
         errors++; $display("FAIL flush_dropped: ov=%b en=%b want 0 0", out_valid, wb_en);
      end
   endtask

   task automatic test_random();
      mem_wb_payload_t h;
      bit exp_en, exp_en0;
      for (int c = 0; c < 400; c++) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
               {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom_range(0, 31)));
         out_ready = $urandom_range(0, 2) != 0;
         flush     = $urandom_range(0, 15) == 0;
         #1;
         checks++; if (in_ready !== (mq.size() < 2) || out_valid !== (mq.size() > 0) ||
                       in_ready0 !== (mq.size() < 2) || out_valid0 !== (mq.size() > 0)) begin
            errors++; $display("FAIL rnd_hs[%0d]: ir=%b ov=%b ir0=%b ov0=%b want ir=%b ov=%b", c,
                               in_ready, out_valid, in_ready0, out_valid0, mq.size() < 2, mq.size() > 0);
         end
         if (mq.size() > 0) begin
            h = mq[0];
            exp_en0 = out_ready && h.reg_write;
            exp_en  = exp_en0 && (h.rd != 5'd0);
            checks++; if (RegWrite_store !== h.reg_write || MemtoReg_store !== h.mem_to_reg ||
                          ReadData_store !== h.read_data || ALU_result_store !== h.alu_result ||
                          rd_store !== h.rd || rd_store0 !== h.rd || ALU_result_store0 !== h.alu_result ||
                          ReadData_store0 !== h.read_data || MemtoReg_store0 !== h.mem_to_reg ||
                          RegWrite_store0 !== h.reg_write) begin
               errors++; $display("FAIL rnd_head[%0d]: rd=%0d alu=%h want rd=%0d alu=%h", c,
                                  rd_store, ALU_result_store, h.rd, h.alu_result);
            end
            checks++; if (wb_data !== (h.mem_to_reg ? h.read_data : h.alu_result) ||
                          wb_data0 !== (h.mem_to_reg ? h.read_data : h.alu_result) ||
                          wb_en !== exp_en || wb_en0 !== exp_en0) begin
               errors++; $display("FAIL rnd_wb[%0d]: data=%h en=%b en0=%b want en=%b en0=%b", c,
                                  wb_data, wb_en, wb_en0, exp_en, exp_en0);
            end
         end else begin
            checks++; if (RegWrite_store !== 1'b0 || wb_en !== 1'b0 || RegWrite_store0 !== 1'b0 || wb_en0 !== 1'b0) begin
               errors++; $display("FAIL rnd_empty[%0d]: rw=%b en=%b rw0=%b en0=%b want 0", c,
                                  RegWrite_store, wb_en, RegWrite_store0, wb_en0);
            end
         end
         tick();
      end
      flush = 1'b0; in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_load_and_x0();
      test_flush();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
